// File: rtl/cbfp_pkg.sv
// Shared CBFP constants and types for the stage-1 normalizer and its inverse.
// Both sides must agree on widths and on the index clamp.
package cbfp_pkg;

    localparam int BW_IN           = 12;
    localparam int BW_OUT          = 25;
    localparam int TARGET_INT_BITS = 13;
    localparam int MAX_INDEX       = 24;
    localparam int BATCH_SIZE      = 16;
    localparam int FRAME_BATCHES   = 32;

    typedef logic        [4:0]        index_t;
    typedef logic        [4:0]        pos_t;
    typedef logic signed [BW_IN-1:0]  mant_t;
    typedef logic signed [BW_OUT-1:0] samp_t;

    function automatic index_t clamp_index(input index_t idx);
        return (idx > index_t'(MAX_INDEX)) ? index_t'(MAX_INDEX) : idx;
    endfunction

endpackage

// File: rtl/cbfp_denorm_stage_if.sv
// Batch bus into and out of the CBFP denormalizer; no backpressure in either direction.
// The master drives mantissa batches and observes restored samples plus frame flags.
interface cbfp_denorm_stage_if;
    import cbfp_pkg::*;

    mant_t  [BATCH_SIZE-1:0] real_in;
    mant_t  [BATCH_SIZE-1:0] imag_in;
    index_t [BATCH_SIZE-1:0] index_in;
    logic                    in_valid;

    samp_t  [BATCH_SIZE-1:0] real_out;
    samp_t  [BATCH_SIZE-1:0] imag_out;
    logic                    valid_out;
    logic                    frame_first;
    logic                    frame_last;
    logic                    index_err;

    modport master (
        output real_in, imag_in, index_in, in_valid,
        input  real_out, imag_out, valid_out, frame_first, frame_last, index_err
    );

    modport slave (
        input  real_in, imag_in, index_in, in_valid,
        output real_out, imag_out, valid_out, frame_first, frame_last, index_err
    );

endinterface

// File: rtl/cbfp_denorm_lane.sv
// One lane of the denormalizer: clamps the block index, then shifts both components back to fixed point.
// Purely combinational; left shifts are exact, right shifts floor toward minus infinity.
module cbfp_denorm_lane
    import cbfp_pkg::*;
(
    input  mant_t  re_in,
    input  mant_t  im_in,
    input  index_t idx_in,
    output samp_t  re_out,
    output samp_t  im_out
);

    index_t idx_eff;
    index_t amt;
    logic   shift_left;

    always_comb begin
        idx_eff    = clamp_index(idx_in);
        shift_left = (idx_eff <= index_t'(TARGET_INT_BITS));
        amt        = shift_left ? (index_t'(TARGET_INT_BITS) - idx_eff)
                                : (idx_eff - index_t'(TARGET_INT_BITS));
        // Sign-extend before shifting so the left shift cannot overflow the mantissa width.
        re_out     = shift_left ? (samp_t'(re_in) <<< amt) : (samp_t'(re_in) >>> amt);
        im_out     = shift_left ? (samp_t'(im_in) <<< amt) : (samp_t'(im_in) >>> amt);
    end

endmodule

// File: rtl/cbfp_denorm_stage.sv
// CBFP denormalizer: 16-lane batches of mantissas + block index -> restored samples, 2-cycle pipeline.
// Tags each batch with its position in a 32-batch frame and flags out-of-range indices per batch.
module cbfp_denorm_stage
    import cbfp_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    cbfp_denorm_stage_if.slave io
);

    logic                    s1_vld_q, s1_vld_d;
    mant_t  [BATCH_SIZE-1:0] s1_re_q, s1_re_d;
    mant_t  [BATCH_SIZE-1:0] s1_im_q, s1_im_d;
    index_t [BATCH_SIZE-1:0] s1_idx_q, s1_idx_d;
    logic                    s1_err_q, s1_err_d;
    pos_t                    s1_pos_q, s1_pos_d;
    pos_t                    cnt_q, cnt_d;

    logic                    out_vld_q, out_vld_d;
    samp_t  [BATCH_SIZE-1:0] out_re_q, out_re_d;
    samp_t  [BATCH_SIZE-1:0] out_im_q, out_im_d;
    logic                    out_first_q, out_first_d;
    logic                    out_last_q, out_last_d;
    logic                    out_err_q, out_err_d;

    samp_t  [BATCH_SIZE-1:0] lane_re;
    samp_t  [BATCH_SIZE-1:0] lane_im;

    for (genvar g = 0; g < BATCH_SIZE; g++) begin : g_lane
        cbfp_denorm_lane u_lane (
            .re_in  (s1_re_q[g]),
            .im_in  (s1_im_q[g]),
            .idx_in (s1_idx_q[g]),
            .re_out (lane_re[g]),
            .im_out (lane_im[g])
        );
    end

    always_comb begin
        s1_vld_d = io.in_valid;
        s1_re_d  = io.real_in;
        s1_im_d  = io.imag_in;
        s1_idx_d = io.index_in;
        s1_pos_d = cnt_q;
        s1_err_d = 1'b0;
        for (int i = 0; i < BATCH_SIZE; i++) begin
            if (io.index_in[i] > index_t'(MAX_INDEX)) begin
                s1_err_d = 1'b1;
            end
        end
        // Gaps hold the position so a frame can straddle idle cycles.
        cnt_d = cnt_q;
        if (io.in_valid) begin
            cnt_d = (cnt_q == pos_t'(FRAME_BATCHES - 1)) ? '0 : cnt_q + 5'd1;
        end
    end

    always_comb begin
        out_vld_d   = s1_vld_q;
        out_re_d    = s1_vld_q ? lane_re : '0;
        out_im_d    = s1_vld_q ? lane_im : '0;
        out_first_d = s1_vld_q && (s1_pos_q == '0);
        out_last_d  = s1_vld_q && (s1_pos_q == pos_t'(FRAME_BATCHES - 1));
        out_err_d   = s1_vld_q && s1_err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_re_q     <= '0;
            s1_im_q     <= '0;
            s1_idx_q    <= '0;
            s1_err_q    <= 1'b0;
            s1_pos_q    <= '0;
            cnt_q       <= '0;
            out_vld_q   <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_re_q     <= s1_re_d;
            s1_im_q     <= s1_im_d;
            s1_idx_q    <= s1_idx_d;
            s1_err_q    <= s1_err_d;
            s1_pos_q    <= s1_pos_d;
            cnt_q       <= cnt_d;
            out_vld_q   <= out_vld_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_first_q <= out_first_d;
            out_last_q  <= out_last_d;
            out_err_q   <= out_err_d;
        end
    end

    assign io.real_out    = out_re_q;
    assign io.imag_out    = out_im_q;
    assign io.valid_out   = out_vld_q;
    assign io.frame_first = out_first_q;
    assign io.frame_last  = out_last_q;
    assign io.index_err   = out_err_q;

endmodule
